// File: rtl/sr_bank_arbiter.sv
// Shared SR flag bank with a round-robin arbiter in front of it.
// One command per cycle updates a flag; ack follows one cycle later.
module sr_bank_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_FLAGS = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_all,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      cmd,
  input  logic [ADDR_W*N_REQ-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    ack,
  output logic [2:0]              ack_id,
  output logic [N_FLAGS-1:0]      Q,
  output logic [N_FLAGS-1:0]      Q_bar,
  output logic [7:0]              err_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] CMD_CLR = 2'b01;
  localparam logic [1:0] CMD_SET = 2'b10;
  localparam logic [1:0] CMD_ERR = 2'b11;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic               acc;
  logic [1:0]         win_cmd;
  logic [ADDR_W-1:0]  win_addr;
  logic [N_FLAGS-1:0] q_r;
  logic [7:0]         err_r;
  logic               ack_r;
  logic [2:0]         ack_id_r;

  logic [1:0]        cmd_a  [N_REQ];
  logic [ADDR_W-1:0] addr_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign cmd_a[g]  = cmd[2*g +: 2];
    assign addr_a[g] = addr[ADDR_W*g +: ADDR_W];
  end

  // Round-robin pick: scan from ptr upward, first asserted req wins.
  always_comb begin
    logic [PTR_W-1:0] slot;
    int               s;
    gnt  = '0;
    win  = '0;
    acc  = 1'b0;
    slot = '0;
    s    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      slot = PTR_W'(s);
      if (!acc && req[slot]) begin
        acc       = 1'b1;
        win       = slot;
        gnt[slot] = 1'b1;
      end
    end
    if (rst || clr_all) begin
      gnt = '0;
      acc = 1'b0;
    end
  end

  assign win_cmd  = cmd_a[win];
  assign win_addr = addr_a[win];

  // Pointer moves past the winner only when a command is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (acc) begin
      ptr <= PTR_W'((int'(win) + 1) % N_REQ);
    end
  end

  // Flag bank: clear-all wins, otherwise set/clear the addressed flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (clr_all) begin
      q_r <= '0;
    end else if (acc) begin
      for (int f = 0; f < N_FLAGS; f++) begin
        if (win_addr == ADDR_W'(f)) begin
          if (win_cmd == CMD_SET) q_r[f] <= 1'b1;
          else if (win_cmd == CMD_CLR) q_r[f] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of illegal S=R=1 commands, any address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= '0;
    end else if (acc && win_cmd == CMD_ERR && err_r != 8'hFF) begin
      err_r <= err_r + 8'd1;
    end
  end

  // One-cycle ack pulse; ack_id keeps the last acknowledged requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r    <= 1'b0;
      ack_id_r <= '0;
    end else begin
      ack_r <= acc;
      if (acc) ack_id_r <= 3'(win);
    end
  end

  assign Q       = q_r;
  assign Q_bar   = ~q_r;
  assign err_cnt = err_r;
  assign ack     = ack_r;
  assign ack_id  = ack_id_r;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter.
// Hand-computed expectations, one check task.
module tb_sr_bank_arbiter;

  logic       clk;
  logic       rst;
  logic       clr_all;
  logic [3:0] req;
  logic [7:0] cmd;
  logic [11:0] addr;
  logic [3:0] gnt;
  logic       ack;
  logic [2:0] ack_id;
  logic [7:0] Q;
  logic [7:0] Q_bar;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  sr_bank_arbiter #(.N_REQ(4), .N_FLAGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .clr_all(clr_all),
    .req(req), .cmd(cmd), .addr(addr),
    .gnt(gnt), .ack(ack), .ack_id(ack_id),
    .Q(Q), .Q_bar(Q_bar), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i,
                         input logic [1:0] c,
                         input logic [2:0] a);
    cmd[2*i +: 2]  = c;
    addr[3*i +: 3] = a;
  endtask

  initial begin
    logic q_moved;
    rst = 1'b1; clr_all = 1'b0;
    req = '0; cmd = '0; addr = '0;
    #1;
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_qbar", 32'(Q_bar), 32'hFF);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ackid", 32'(ack_id), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    req = 4'b0001;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    #10;
    rst = 1'b0;

    // set flag 5 from requester 0
    set_cmd(0, 2'b10, 3'd5);
    #1;
    chk("first_gnt", 32'(gnt), 32'b0001);
    tick();
    req = '0;
    chk("first_q", 32'(Q), 32'h20);
    chk("first_qbar", 32'(Q_bar), 32'hDF);
    chk("first_ack", 32'(ack), 32'd1);
    chk("first_ackid", 32'(ack_id), 32'd0);
    tick();
    chk("ack_drop", 32'(ack), 32'd0);
    chk("ackid_hold", 32'(ack_id), 32'd0);

    // rotation from ptr 0 with all four requesting no-ops
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cmd = '0; addr = '0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      tick();
      chk("rr_ack", 32'(ack), 32'd1);
      chk("rr_ackid", 32'(ack_id), 32'(k % 4));
    end
    chk("rr_q", 32'(Q), 32'h00);
    req = '0;
    tick();

    // ptr=1: requester 0 sets bit 5, then requester 2 toggles bit 3
    req = 4'b0001;
    set_cmd(0, 2'b10, 3'd5);
    tick();
    chk("pre_q", 32'(Q), 32'h20);
    req = 4'b0100;
    set_cmd(2, 2'b10, 3'd3);
    tick();
    chk("set3_q", 32'(Q), 32'h28);
    chk("set3_ackid", 32'(ack_id), 32'd2);
    set_cmd(2, 2'b01, 3'd3);
    tick();
    chk("clr3_q", 32'(Q), 32'h20);
    chk("clr3_ack", 32'(ack), 32'd1);
    req = '0;
    tick();

    // illegal commands saturate err_cnt, flags untouched
    req = 4'b0001;
    set_cmd(0, 2'b11, 3'd5);
    q_moved = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (Q !== 8'h20) q_moved = 1'b1;
      if (i == 253) chk("err_254", 32'(err_cnt), 32'd254);
      if (i == 254) chk("err_255", 32'(err_cnt), 32'd255);
    end
    chk("err_sat", 32'(err_cnt), 32'd255);
    chk("err_q_stable", 32'(q_moved), 32'd0);
    chk("err_ack", 32'(ack), 32'd1);

    // fill every flag; ptr ends at 1
    for (int a = 0; a < 8; a++) begin
      set_cmd(0, 2'b10, 3'(a));
      tick();
    end
    chk("fill_q", 32'(Q), 32'hFF);
    req = 4'b1111;
    cmd = '0;
    clr_all = 1'b1;
    #1;
    chk("clr_gnt", 32'(gnt), 32'd0);
    tick();
    chk("clr_q", 32'(Q), 32'h00);
    chk("clr_qbar", 32'(Q_bar), 32'hFF);
    chk("clr_ack", 32'(ack), 32'd0);
    chk("clr_err", 32'(err_cnt), 32'd255);
    clr_all = 1'b0;
    #1;
    chk("clr_ptr", 32'(gnt), 32'b0010);

    // requester 1 sets bit 6; ptr moves to 2
    req = 4'b0010;
    set_cmd(1, 2'b10, 3'd6);
    tick();
    chk("r1_q", 32'(Q), 32'h40);
    chk("r1_ack", 32'(ack), 32'd1);

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", 32'(Q), 32'h00);
    chk("arst_qbar", 32'(Q_bar), 32'hFF);
    chk("arst_err", 32'(err_cnt), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_ackid", 32'(ack_id), 32'd0);
    chk("arst_gnt", 32'(gnt), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_gnt", 32'(gnt), 32'b0010);
    tick();
    chk("post_ack", 32'(ack), 32'd1);
    chk("post_ackid", 32'(ack_id), 32'd1);
    chk("post_q", 32'(Q), 32'h40);
    req = 4'b1111;
    cmd = '0;
    #1;
    chk("post_ptr", 32'(gnt), 32'b0100);
    req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
